// File: rtl/execute_stage.sv
// Execute stage: condition evaluation, ALU with NZCV flags, 32-cycle shift-add
// multiply, and the EX/MEM pipeline register. All state moves on the falling edge.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [1:0]  FlagWriteE,
  input  logic [3:0]  condE,
  input  logic [3:0]  WA3E,
  input  logic [31:0] rd1E,
  input  logic [31:0] rd2E,
  input  logic [31:0] ExtImmE,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [3:0]  WA3M,
  output logic [3:0]  flags_o,
  output logic        stall_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_mcand, r_mplier, r_acc;
  logic [4:0]  r_cnt;
  logic [3:0]  r_flags;
  logic [31:0] w_srcb, w_bop, w_res;
  logic [32:0] w_sum;
  logic        w_sub, w_c, w_v, w_condex, w_stall;
  logic        w_n, w_z, w_fc, w_fv;

  assign {w_n, w_z, w_fc, w_fv} = r_flags;
  assign flags_o = r_flags;

  assign w_srcb = ALUSrcE ? ExtImmE : rd2E;
  assign w_sub  = (ALUControlE == 3'b001);
  assign w_bop  = w_sub ? ~w_srcb : w_srcb;
  assign w_sum  = {1'b0, rd1E} + {1'b0, w_bop} + {32'b0, w_sub};

  always_comb begin
    w_condex = 1'b0;
    case (condE)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_fc;
      4'b0011: w_condex = ~w_fc;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_fv;
      4'b0111: w_condex = ~w_fv;
      4'b1000: w_condex = w_fc & ~w_z;
      4'b1001: w_condex = ~w_fc | w_z;
      4'b1010: w_condex = (w_n == w_fv);
      4'b1011: w_condex = (w_n != w_fv);
      4'b1100: w_condex = ~w_z & (w_n == w_fv);
      4'b1101: w_condex = w_z | (w_n != w_fv);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  always_comb begin
    w_res = w_sum[31:0];
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ALUControlE)
      3'b000, 3'b001: begin
        w_c = w_sum[32];
        w_v = (rd1E[31] == w_bop[31]) & (w_sum[31] != rd1E[31]);
      end
      3'b010:  w_res = rd1E & w_srcb;
      3'b011:  w_res = rd1E | w_srcb;
      3'b100:  w_res = w_srcb;
      3'b101:  w_res = r_acc;
      3'b110:  w_res = rd1E ^ w_srcb;
      default: w_res = rd1E & ~w_srcb;
    endcase
  end

  // A MUL whose condition fails never enters BUSY and passes as a bubble.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: if (ALUControlE == 3'b101 && w_condex) begin
        w_stall = 1'b1;
        w_next  = BUSY;
      end
      BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == 5'd31) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign stall_o = w_stall & ~rst;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 5'd0;
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == BUSY) begin
        r_mcand  <= rd1E;
        r_mplier <= w_srcb;
        r_acc    <= 32'd0;
        r_cnt    <= 5'd0;
      end else if (r_state == BUSY) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 5'd1;
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      PCSrcM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      WA3M       <= 4'd0;
      r_flags    <= 4'd0;
    end else if (w_stall) begin
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
    end else begin
      PCSrcM     <= (PCSrcE | BranchE) & w_condex;
      RegWriteM  <= RegWriteE & w_condex;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE & w_condex;
      ALUResultM <= w_res;
      WriteDataM <= rd2E;
      WA3M       <= WA3E;
      if (w_condex) begin
        if (FlagWriteE[1]) r_flags[3:2] <= {w_res[31], (w_res == 32'd0)};
        if (FlagWriteE[0]) r_flags[1:0] <= {w_c, w_v};
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, reset-abort sequence and
// randomized instructions checked against an arithmetic reference model.
module tb_execute_stage;
  logic        clk = 1'b0, rst;
  logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [1:0]  FlagWriteE;
  logic [3:0]  condE, WA3E;
  logic [31:0] rd1E, rd2E, ExtImmE;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM, stall_o;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WA3M, flags_o;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .FlagWriteE(FlagWriteE), .condE(condE), .WA3E(WA3E), .rd1E(rd1E), .rd2E(rd2E),
    .ExtImmE(ExtImmE), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .flags_o(flags_o), .stall_o(stall_o)
  );

  typedef struct {
    logic [2:0] op; logic [3:0] cond; logic [1:0] fw;
    logic alusrc, rw, mw, m2r, pcs, br; logic [3:0] wa3;
    logic [31:0] a, b, imm;
  } vec_t;
  typedef struct {
    logic [31:0] res; logic chk_res; logic [3:0] flags;
    logic rw, mw, pcs, m2r; int stalls;
  } exp_t;
  typedef struct { vec_t v; exp_t e; } rec_t;

  int tests = 0, fails = 0;
  logic [3:0] mflags;
  rec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] cond, input logic [1:0] fw,
                              input logic alusrc, input logic rw, input logic mw,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                              input logic [3:0] wa3);
    vec_t v;
    v.op = op; v.cond = cond; v.fw = fw; v.alusrc = alusrc; v.rw = rw; v.mw = mw;
    v.a = a; v.b = b; v.imm = imm; v.wa3 = wa3; v.m2r = 1'b0; v.pcs = 1'b0; v.br = 1'b0;
    return v;
  endfunction

  function automatic exp_t mke(input logic [31:0] res, input logic chk_res, input logic [3:0] fl,
                               input logic rw, input logic mw, input int st);
    exp_t e;
    e.res = res; e.chk_res = chk_res; e.flags = fl; e.rw = rw; e.mw = mw;
    e.pcs = 1'b0; e.m2r = 1'b0; e.stalls = st;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    ALUControlE = v.op; condE = v.cond; FlagWriteE = v.fw; ALUSrcE = v.alusrc;
    RegWriteE = v.rw; MemWriteE = v.mw; MemtoRegE = v.m2r; PCSrcE = v.pcs; BranchE = v.br;
    WA3E = v.wa3; rd1E = v.a; rd2E = v.b; ExtImmE = v.imm;
  endtask

  // Reference: condition from the flag meanings, results from plain integer arithmetic.
  task automatic model(input vec_t v, output exp_t e);
    logic n, z, c, vv, cx, co, ov;
    logic [31:0] b, r;
    longint sa, sb, sr;
    {n, z, c, vv} = mflags;
    case (v.cond)
      4'd0: cx = z;        4'd1: cx = !z;       4'd2: cx = c;        4'd3: cx = !c;
      4'd4: cx = n;        4'd5: cx = !n;       4'd6: cx = vv;       4'd7: cx = !vv;
      4'd8: cx = c && !z;  4'd9: cx = !c || z;  4'd10: cx = n == vv; 4'd11: cx = n != vv;
      4'd12: cx = !z && (n == vv); 4'd13: cx = z || (n != vv);
      4'd14: cx = 1'b1;    default: cx = 1'b0;
    endcase
    b = v.alusrc ? v.imm : v.b;
    sa = longint'($signed(v.a));
    sb = longint'($signed(b));
    co = 1'b0; ov = 1'b0; sr = 0;
    case (v.op)
      3'd0: begin r = v.a + b; co = ({32'b0, v.a} + {32'b0, b}) > 64'hFFFF_FFFF; sr = sa + sb; end
      3'd1: begin r = v.a - b; co = (v.a >= b); sr = sa - sb; end
      3'd2: r = v.a & b;
      3'd3: r = v.a | b;
      3'd4: r = b;
      3'd5: r = v.a * b;
      3'd6: r = v.a ^ b;
      default: r = v.a & ~b;
    endcase
    if (v.op <= 3'd1) ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.res = r; e.chk_res = !(v.op == 3'd5 && !cx);
    e.rw = v.rw & cx; e.mw = v.mw & cx; e.pcs = (v.pcs | v.br) & cx; e.m2r = v.m2r;
    e.stalls = (v.op == 3'd5 && cx) ? 33 : 0;
    if (cx) begin
      if (v.fw[1]) mflags[3:2] = {r[31], r == 32'd0};
      if (v.fw[0]) mflags[1:0] = {co, ov};
    end
    e.flags = mflags;
  endtask

  task automatic run(input string nm, input vec_t v, input exp_t e);
    int n = 0;
    @(posedge clk); drive(v); #1;
    while (stall_o === 1'b1 && n < 40) begin
      @(negedge clk); #1;
      n++;
      chk({nm, "_bubble_rw"}, {31'b0, RegWriteM}, 32'd0);
    end
    chk({nm, "_stalls"}, n, e.stalls);
    @(negedge clk); #1;
    if (e.chk_res) chk({nm, "_res"}, ALUResultM, e.res);
    chk({nm, "_rw"},    {31'b0, RegWriteM}, {31'b0, e.rw});
    chk({nm, "_mw"},    {31'b0, MemWriteM}, {31'b0, e.mw});
    chk({nm, "_pcs"},   {31'b0, PCSrcM},    {31'b0, e.pcs});
    chk({nm, "_m2r"},   {31'b0, MemtoRegM}, {31'b0, e.m2r});
    chk({nm, "_wa3"},   {28'b0, WA3M},      {28'b0, v.wa3});
    chk({nm, "_wdata"}, WriteDataM, v.b);
    chk({nm, "_flags"}, {28'b0, flags_o},   {28'b0, e.flags});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_res"},   ALUResultM, 32'd0);
    chk({nm, "_wdata"}, WriteDataM, 32'd0);
    chk({nm, "_ctl"},   {26'b0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM, stall_o, 1'b0}, 32'd0);
    chk({nm, "_wa3"},   {28'b0, WA3M}, 32'd0);
    chk({nm, "_flags"}, {28'b0, flags_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    exp_t e, d;
    rst = 1'b1;
    drive(mk(3'd5, 4'he, 2'b11, 1'b0, 1'b1, 1'b1, 32'd9, 32'd9, 32'd0, 4'd1));
    mflags = 4'd0;
    #12;
    chk_zero("reset");
    drive(mk(3'd0, 4'hf, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0));
    @(posedge clk); rst = 1'b0;

    tbl[0].v  = mk(3'd0, 4'he, 2'b00, 1'b1, 1'b1, 1'b0, 32'd5, 32'd0, 32'd7, 4'd3);
    tbl[0].e  = mke(32'd12, 1'b1, 4'b0000, 1'b1, 1'b0, 0);
    tbl[1].v  = mk(3'd1, 4'he, 2'b11, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0, 4'd2);
    tbl[1].e  = mke(32'd0, 1'b1, 4'b0110, 1'b0, 1'b0, 0);
    tbl[2].v  = mk(3'd0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 32'd0, 4'd4);
    tbl[2].e  = mke(32'd2, 1'b1, 4'b0110, 1'b1, 1'b0, 0);
    tbl[3].v  = mk(3'd0, 4'h1, 2'b11, 1'b0, 1'b1, 1'b1, 32'd2, 32'd2, 32'd0, 4'd5);
    tbl[3].e  = mke(32'd4, 1'b1, 4'b0110, 1'b0, 1'b0, 0);
    tbl[4].v  = mk(3'd5, 4'he, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0001_0001, 32'h0000_FFFF, 32'd0, 4'd6);
    tbl[4].e  = mke(32'hFFFF_FFFF, 1'b1, 4'b1010, 1'b1, 1'b0, 33);
    tbl[5].v  = mk(3'd5, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 4'd7);
    tbl[5].e  = mke(32'd0, 1'b0, 4'b1010, 1'b0, 1'b0, 0);
    tbl[6].v  = mk(3'd0, 4'he, 2'b11, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd0, 32'd1, 4'd8);
    tbl[6].e  = mke(32'h8000_0000, 1'b1, 4'b1001, 1'b1, 1'b0, 0);
    tbl[7].v  = mk(3'd1, 4'he, 2'b11, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1, 32'd0, 4'd9);
    tbl[7].e  = mke(32'hFFFF_FFFF, 1'b1, 4'b1000, 1'b1, 1'b0, 0);
    tbl[8].v  = mk(3'd2, 4'he, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 4'd10);
    tbl[8].v.br = 1'b1; tbl[8].v.m2r = 1'b1;
    tbl[8].e  = mke(32'h0000_F000, 1'b1, 4'b0000, 1'b0, 1'b0, 0);
    tbl[8].e.pcs = 1'b1; tbl[8].e.m2r = 1'b1;
    tbl[9].v  = mk(3'd7, 4'hb, 2'b11, 1'b0, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_0F0F, 32'd0, 4'd11);
    tbl[9].v.pcs = 1'b1; tbl[9].v.m2r = 1'b1;
    tbl[9].e  = mke(32'h0000_F0F0, 1'b1, 4'b0000, 1'b0, 1'b0, 0);
    tbl[9].e.m2r = 1'b1;
    tbl[10].v = mk(3'd6, 4'ha, 2'b10, 1'b0, 1'b1, 1'b0, 32'hFF, 32'hFF, 32'd0, 4'd12);
    tbl[10].e = mke(32'd0, 1'b1, 4'b0100, 1'b1, 1'b0, 0);
    tbl[11].v = mk(3'd4, 4'he, 2'b11, 1'b1, 1'b1, 1'b0, 32'd1, 32'd2, 32'h8000_0000, 4'd13);
    tbl[11].e = mke(32'h8000_0000, 1'b1, 4'b1000, 1'b1, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      model(tbl[i].v, d);
      run($sformatf("vec%0d", i), tbl[i].v, tbl[i].e);
    end

    // Reset in the middle of a multiply aborts it.
    @(posedge clk);
    drive(mk(3'd5, 4'he, 2'b11, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h5678, 32'd0, 4'd14));
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("rst_busy");
    drive(mk(3'd0, 4'hf, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0));
    mflags = 4'd0;
    @(posedge clk); rst = 1'b0;
    v = mk(3'd5, 4'he, 2'b11, 1'b0, 1'b1, 1'b0, 32'd7, 32'd6, 32'd0, 4'd15);
    model(v, e);
    chk("mul76_model", e.res, 32'd42);
    run("mul76", v, e);

    // Back-to-back multiplies.
    for (int i = 0; i < 2; i++) begin
      v = mk(3'd5, 4'he, 2'b11, 1'b1, 1'b1, 1'b0, $urandom, 32'd0, $urandom, 4'(i));
      model(v, e);
      run($sformatf("b2b%0d", i), v, e);
    end

    for (int i = 0; i < 60; i++) begin
      v.op = 3'($urandom_range(0, 7));
      v.cond = ($urandom_range(0, 3) == 0) ? 4'he : 4'($urandom_range(0, 15));
      v.fw = 2'($urandom_range(0, 3));
      v.alusrc = 1'($urandom); v.rw = 1'($urandom); v.mw = 1'($urandom);
      v.m2r = 1'($urandom); v.pcs = 1'($urandom); v.br = 1'($urandom);
      v.wa3 = 4'($urandom);
      v.a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      v.b = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
      v.imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      model(v, e);
      run($sformatf("rnd%0d", i), v, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
